vm2002_change_dispenser: RTL

VM2002_CHANGE_DISPENSER -- requirements
Module: vm2002_change_dispenser

---
 rtl/vm2002_change_dispenser.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vm2002_change_dispenser.sv
// Change dispenser for the vm2002 vending core: pays a cent balance with
// quarters, dimes and nickels from saturating on-board inventories.
module vm2002_change_dispenser #(
   parameter int INV_W     = 4,
   parameter int QTR_INIT  = 8,
   parameter int DIME_INIT = 8,
   parameter int NICK_INIT = 8
) (
   input  logic             clk,
   input  logic             hrst,
   input  logic             srst,
   input  logic             balance_valid,
   input  logic [7:0]       balance,
   output logic             balance_ready,
   output logic [1:0]       coin_out,
   output logic             coin_valid,
   input  logic             coin_ack,
   input  logic             refill_valid,
   input  logic [INV_W-1:0] refill_q,
   input  logic [INV_W-1:0] refill_d,
   input  logic [INV_W-1:0] refill_n,
   output logic [7:0]       remaining,
   output logic             done,
   output logic             short_change
);

   typedef enum logic [2:0] {IDLE, SELECT, PRESENT, DONE, SHORT} state_t;

   localparam logic [INV_W-1:0] INV_MAX = '1;
   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_NICK = 2'd1;
   localparam logic [1:0] COIN_DIME = 2'd2;
   localparam logic [1:0] COIN_QTR  = 2'd3;

   state_t           state_q, state_d;
   logic [7:0]       remaining_q, remaining_d;
   logic [INV_W-1:0] qtr_cnt_q, qtr_cnt_d;
   logic [INV_W-1:0] dime_cnt_q, dime_cnt_d;
   logic [INV_W-1:0] nick_cnt_q, nick_cnt_d;
   logic [1:0]       coin_sel_q, coin_sel_d;
   logic [1:0]       coin_out_q, coin_out_d;
   logic             coin_valid_q, coin_valid_d;
   logic             done_q, done_d;
   logic             short_q, short_d;
   logic [1:0]       pick;

   function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                input logic [INV_W-1:0] b);
      logic [INV_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[INV_W] ? INV_MAX : sum[INV_W-1:0];
   endfunction

   function automatic logic [7:0] coin_value(input logic [1:0] c);
      case (c)
         COIN_QTR:  return 8'd25;
         COIN_DIME: return 8'd10;
         COIN_NICK: return 8'd5;
         default:   return 8'd0;
      endcase
   endfunction

   // Greedy choice: largest coin that fits the remainder and is in stock.
   always_comb begin
      pick = COIN_NONE;
      if (remaining_q >= 8'd25 && qtr_cnt_q != '0) begin
         pick = COIN_QTR;
      end else if (remaining_q >= 8'd10 && dime_cnt_q != '0) begin
         pick = COIN_DIME;
      end else if (remaining_q >= 8'd5 && nick_cnt_q != '0) begin
         pick = COIN_NICK;
      end
   end

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      qtr_cnt_d    = qtr_cnt_q;
      dime_cnt_d   = dime_cnt_q;
      nick_cnt_d   = nick_cnt_q;
      coin_sel_d   = coin_sel_q;
      coin_out_d   = coin_out_q;
      coin_valid_d = coin_valid_q;
      done_d       = 1'b0;
      short_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (refill_valid) begin
               qtr_cnt_d  = sat_add(qtr_cnt_q, refill_q);
               dime_cnt_d = sat_add(dime_cnt_q, refill_d);
               nick_cnt_d = sat_add(nick_cnt_q, refill_n);
            end
            if (balance_valid) begin
               remaining_d = balance;
               state_d     = SELECT;
            end
         end
         SELECT: begin
            if (pick != COIN_NONE) begin
               coin_sel_d = pick;
               state_d    = PRESENT;
            end else if (remaining_q < 8'd5) begin
               state_d = DONE;
            end else begin
               state_d = SHORT;
            end
         end
         PRESENT: begin
            // The coin is offered one cycle after entering PRESENT, so an
            // ack only counts once coin_valid is already visible.
            if (coin_valid_q && coin_ack) begin
               remaining_d  = remaining_q - coin_value(coin_out_q);
               case (coin_out_q)
                  COIN_QTR:  qtr_cnt_d  = qtr_cnt_q - 1'b1;
                  COIN_DIME: dime_cnt_d = dime_cnt_q - 1'b1;
                  COIN_NICK: nick_cnt_d = nick_cnt_q - 1'b1;
                  default:   ;
               endcase
               coin_valid_d = 1'b0;
               coin_out_d   = COIN_NONE;
               state_d      = SELECT;
            end else begin
               coin_valid_d = 1'b1;
               coin_out_d   = coin_sel_q;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         SHORT: begin
            short_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (hrst) begin
         state_q      <= IDLE;
         remaining_q  <= 8'd0;
         qtr_cnt_q    <= INV_W'(QTR_INIT);
         dime_cnt_q   <= INV_W'(DIME_INIT);
         nick_cnt_q   <= INV_W'(NICK_INIT);
         coin_sel_q   <= COIN_NONE;
         coin_out_q   <= COIN_NONE;
         coin_valid_q <= 1'b0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
      end else if (srst) begin
         // Abort keeps stock untouched, even if an ack lands this cycle.
         state_q      <= IDLE;
         remaining_q  <= 8'd0;
         coin_out_q   <= COIN_NONE;
         coin_valid_q <= 1'b0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         qtr_cnt_q    <= qtr_cnt_d;
         dime_cnt_q   <= dime_cnt_d;
         nick_cnt_q   <= nick_cnt_d;
         coin_sel_q   <= coin_sel_d;
         coin_out_q   <= coin_out_d;
         coin_valid_q <= coin_valid_d;
         done_q       <= done_d;
         short_q      <= short_d;
      end
   end

   assign balance_ready = (state_q == IDLE);
   assign coin_out      = coin_out_q;
   assign coin_valid    = coin_valid_q;
   assign remaining     = remaining_q;
   assign done          = done_q;
   assign short_change  = short_q;

endmodule
